// File: rtl/alu_ex_latch.sv
// EX/MEM boundary latch behind the ALU. It has a 2-entry skid buffer and a valid/ready handshake on both sides.
// Optional feature ALU_OVF_TRAP_EN adds signed-overflow detection on ADD/SUB as a precise trap.
module alu_ex_latch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        aluc,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_negative,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              wen_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_negative,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wen,
  output logic              out_exc,
  output logic [DATA_W-1:0] out_epc
);

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0010;

  typedef struct packed {
    logic [DATA_W-1:0] c;
    logic              zero;
    logic              carry;
    logic              negative;
    logic [REG_W-1:0]  rd;
    logic              wen;
`ifdef ALU_OVF_TRAP_EN
    logic              exc;
    logic [DATA_W-1:0] epc;
`endif
  } entry_t;

  entry_t main_e, skid_e, in_e;
  logic   main_v, skid_v;
  logic   accept, drain, skid_v_nxt;
  logic   unused_ok;

`ifdef ALU_OVF_TRAP_EN
  typedef enum logic {RUN = 1'b0, EXC = 1'b1} state_t;
  state_t state;
  logic   ovf, trap;

  // Overflow judged purely from operand/result sign bits
  always_comb begin
    ovf = 1'b0;
    case (aluc)
      ALUC_ADD: ovf = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (alu_c[DATA_W-1] != alu_a[DATA_W-1]);
      ALUC_SUB: ovf = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (alu_c[DATA_W-1] != alu_a[DATA_W-1]);
      default:  ovf = 1'b0;
    endcase
  end

  assign trap      = accept && ovf;
  assign unused_ok = ^{alu_a[DATA_W-2:0], alu_b[DATA_W-2:0]};
`else
  assign unused_ok = ^{alu_a, alu_b, aluc, pc_in};
`endif

  always_comb begin
    in_e          = '0;
    in_e.c        = alu_c;
    in_e.zero     = alu_zero;
    in_e.carry    = alu_carry;
    in_e.negative = alu_negative;
    in_e.rd       = rd_in;
`ifdef ALU_OVF_TRAP_EN
    in_e.wen      = wen_in && !ovf;
    in_e.exc      = ovf;
    in_e.epc      = ovf ? pc_in : '0;
`else
    in_e.wen      = wen_in;
`endif
  end

  assign accept     = in_valid && in_ready;
  assign drain      = main_v && out_ready;
  // Skid occupancy after this edge; in_ready is registered from it
  assign skid_v_nxt = (skid_v && !drain) || (accept && main_v && !drain);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      main_e   <= '0;
      skid_e   <= '0;
      in_ready <= 1'b1;
`ifdef ALU_OVF_TRAP_EN
      state    <= RUN;
`endif
    end else begin
      if (drain && skid_v) begin
        main_e <= skid_e;
        skid_v <= 1'b0;
      end else if (accept && (!main_v || drain)) begin
        main_e <= in_e;
        main_v <= 1'b1;
      end else if (accept) begin
        skid_e <= in_e;
        skid_v <= 1'b1;
      end else if (drain) begin
        main_v <= 1'b0;
      end
`ifdef ALU_OVF_TRAP_EN
      if (trap) state <= EXC;
      in_ready <= !skid_v_nxt && (state == RUN) && !trap;
`else
      in_ready <= !skid_v_nxt;
`endif
    end
  end

  assign out_valid    = main_v;
  assign out_c        = main_e.c;
  assign out_zero     = main_e.zero;
  assign out_carry    = main_e.carry;
  assign out_negative = main_e.negative;
  assign out_rd       = main_e.rd;
  assign out_wen      = main_e.wen;
`ifdef ALU_OVF_TRAP_EN
  assign out_exc      = main_e.exc;
  assign out_epc      = main_e.epc;
`else
  assign out_exc      = 1'b0;
  assign out_epc      = '0;
`endif

endmodule

// File: tb/tb_alu_ex_latch.sv
// Bench for alu_ex_latch: directed cases with literal expectations, then random traffic checked against a queue model.
module tb_alu_ex_latch;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0, in_ready;
  logic [DATA_W-1:0] alu_a = '0, alu_b = '0, alu_c = '0, pc_in = '0;
  logic [3:0]        aluc = 4'd1;
  logic              alu_zero = 1'b0, alu_carry = 1'b0, alu_negative = 1'b0;
  logic [REG_W-1:0]  rd_in = '0;
  logic              wen_in = 1'b0, flush = 1'b0;
  logic              out_valid, out_ready = 1'b1;
  logic [DATA_W-1:0] out_c, out_epc;
  logic              out_zero, out_carry, out_negative, out_wen, out_exc;
  logic [REG_W-1:0]  out_rd;

  alu_ex_latch #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc), .alu_c(alu_c),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
    .rd_in(rd_in), .wen_in(wen_in), .pc_in(pc_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_zero(out_zero), .out_carry(out_carry), .out_negative(out_negative),
    .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc), .out_epc(out_epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        z, cy, n;
    logic [4:0]  rd;
    logic        wen, exc;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  bit   trapped  = 1'b0;
  bit   last_acc = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Overflow as signed-number sign comparisons on the offered operands
  function automatic bit is_ovf();
`ifdef ALU_OVF_TRAP_EN
    bit sa, sb, sc;
    sa = $signed(alu_a) < 0;
    sb = $signed(alu_b) < 0;
    sc = $signed(alu_c) < 0;
    if (aluc == 4'd0) return (sa == sb) && (sc != sa);
    if (aluc == 4'd2) return (sa != sb) && (sc != sa);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk_entry();
    exp_t e;
    bit   o;
    o     = is_ovf();
    e.c   = alu_c;
    e.z   = alu_zero;
    e.cy  = alu_carry;
    e.n   = alu_negative;
    e.rd  = rd_in;
    e.wen = o ? 1'b0 : wen_in;
    e.exc = o;
    e.epc = o ? pc_in : 32'h0;
    return e;
  endfunction

  function automatic bit exp_in_ready();
    return (q.size() < 2) && !trapped;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    chk("in_ready", 64'(in_ready), 64'(exp_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_c", 64'(out_c), 64'(q[0].c));
      chk("out_flags", 64'({out_zero, out_carry, out_negative}), 64'({q[0].z, q[0].cy, q[0].n}));
      chk("out_rd", 64'(out_rd), 64'(q[0].rd));
      chk("out_wen", 64'(out_wen), 64'(q[0].wen));
      chk("out_exc", 64'(out_exc), 64'(q[0].exc));
      chk("out_epc", 64'(out_epc), 64'(q[0].epc));
    end
  endtask

  // Advance the model over one edge using the inputs now applied, then check the DUT
  task automatic tick();
    bit   acc, drn;
    exp_t e;
    acc = 1'b0;
    if (rst || flush) begin
      q.delete();
      trapped = 1'b0;
    end else begin
      acc = in_valid && exp_in_ready();
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) begin
        e = mk_entry();
        q.push_back(e);
        if (e.exc) trapped = 1'b1;
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] pc);
    in_valid     = 1'b1;
    aluc         = op;
    alu_a        = a;
    alu_b        = b;
    alu_c        = c;
    alu_zero     = (c == 32'h0);
    alu_carry    = 1'b0;
    alu_negative = c[31];
    rd_in        = 5'(c[4:0] + 5'd1);
    wen_in       = 1'b1;
    pc_in        = pc;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] sp [4];
    sp[0] = 32'h7FFFFFFF; sp[1] = 32'h80000000; sp[2] = 32'hFFFFFFFF; sp[3] = 32'h0;
    if ($urandom_range(3) == 0) return sp[$urandom_range(3)];
    return $urandom;
  endfunction

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_c", 64'(out_c), 64'd0);
    chk("rst_flags_rd_wen", 64'({out_zero, out_carry, out_negative, out_rd, out_wen}), 64'd0);
    chk("rst_exc_epc", 64'({out_exc, out_epc}), 64'd0);

    // Back-to-back accepts, zero flag only on the third
    out_ready = 1'b1;
    set_in(4'd1, 32'd1, 32'd4, 32'h00000005, 32'h100);
    tick();
    chk("b2b0_c", 64'(out_c), 64'h5);
    chk("b2b0_zero", 64'(out_zero), 64'd0);
    chk("b2b0_wen", 64'(out_wen), 64'd1);
    set_in(4'd1, 32'd1, 32'd4, 32'hFFFFFFFF, 32'h104);
    tick();
    chk("b2b1_c", 64'(out_c), 64'hFFFFFFFF);
    chk("b2b1_zero", 64'(out_zero), 64'd0);
    set_in(4'd1, 32'd1, 32'd4, 32'h0, 32'h108);
    tick();
    chk("b2b2_zero", 64'(out_zero), 64'd1);
    chk("b2b2_wen", 64'(out_wen), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle", 64'(out_valid), 64'd0);

    // ADD overflow
    set_in(4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00400010);
    tick();
    in_valid = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    chk("add_ovf_exc", 64'(out_exc), 64'd1);
    chk("add_ovf_wen", 64'(out_wen), 64'd0);
    chk("add_ovf_epc", 64'(out_epc), 64'h00400010);
    chk("add_ovf_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("exc_hold_in_ready", 64'(in_ready), 64'd0);
`else
    chk("add_noovf_exc", 64'(out_exc), 64'd0);
    chk("add_noovf_wen", 64'(out_wen), 64'd1);
    chk("add_noovf_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("add_noovf_in_ready2", 64'(in_ready), 64'd1);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // SUB overflow, then ADDU with the ADD-overflow operands
    set_in(4'd2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h00400020);
    tick();
    in_valid = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    chk("sub_ovf_exc", 64'(out_exc), 64'd1);
`else
    chk("sub_noovf_exc", 64'(out_exc), 64'd0);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(4'd1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00400030);
    tick();
    in_valid = 1'b0;
    chk("addu_exc", 64'(out_exc), 64'd0);
    chk("addu_wen", 64'(out_wen), 64'd1);
    tick();

    // Backpressure: second entry goes to skid, then both drain in order
    out_ready = 1'b0;
    set_in(4'd1, 32'd0, 32'd0, 32'h11, 32'h200);
    tick();
    set_in(4'd1, 32'd0, 32'd0, 32'h22, 32'h204);
    tick();
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_main_c", 64'(out_c), 64'h11);
    set_in(4'd1, 32'd0, 32'd0, 32'h33, 32'h208);
    tick();
    chk("skid_hold_c", 64'(out_c), 64'h11);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drain_second_valid", 64'(out_valid), 64'd1);
    chk("drain_second_c", 64'(out_c), 64'h22);
    tick();
    chk("drain_done", 64'(out_valid), 64'd0);

    // Flush with both entries full and an offer pending
    out_ready = 1'b0;
    set_in(4'd1, 32'd0, 32'd0, 32'h44, 32'h300);
    tick();
    set_in(4'd1, 32'd0, 32'd0, 32'h55, 32'h304);
    tick();
    set_in(4'd1, 32'd0, 32'd0, 32'h66, 32'h308);
    flush = 1'b1;
    tick();
    chk("flush_full_valid", 64'(out_valid), 64'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("flush_dropped", 64'(out_valid), 64'd0);

    // Random traffic against the queue model
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(299) == 0);
      flush     = ($urandom_range(11) == 0);
      out_ready = ($urandom_range(3) != 0);
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(3) != 0);
        case ($urandom_range(4))
          0:       aluc = 4'd0;
          1:       aluc = 4'd2;
          2:       aluc = 4'd1;
          default: aluc = 4'($urandom);
        endcase
        alu_a = pick_operand();
        alu_b = pick_operand();
        if (aluc == 4'd0)      alu_c = alu_a + alu_b;
        else if (aluc == 4'd2) alu_c = alu_a - alu_b;
        else                   alu_c = $urandom;
        if ($urandom_range(7) == 0) alu_c = $urandom;
        alu_zero     = 1'($urandom);
        alu_carry    = 1'($urandom);
        alu_negative = 1'($urandom);
        rd_in        = 5'($urandom);
        wen_in       = 1'($urandom);
        pc_in        = $urandom;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ex_latch.md
# alu_ex_latch

EX/MEM boundary stage directly downstream of the ALU in the MIPS CPU31 core. It captures the ALU result, flags and writeback control through a valid/ready handshake backed by a 2-entry skid buffer. It detects signed overflow on ADD/SUB from the operand and result signs, and converts it into a precise exception that suppresses register writeback. The memory stage consumes its output.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_W, 5, destination register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers an ALU result this cycle
- in_ready  out  1  block can accept; registered, depends only on state
- alu_a  in  DATA_W  ALU operand A
- alu_b  in  DATA_W  ALU operand B
- aluc  in  4  ALU opcode (ADD=4'b0000, SUB=4'b0010)
- alu_c  in  DATA_W  ALU result C
- alu_zero, alu_carry, alu_negative  in  1 each  ALU flags
- rd_in  in  REG_W  destination register
- wen_in  in  1  register write enable
- pc_in  in  DATA_W  PC of the instruction
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_c  out  DATA_W  latched result
- out_zero, out_carry, out_negative  out  1 each  latched flags
- out_rd  out  REG_W  latched destination
- out_wen  out  1  write enable, forced 0 on trap
- out_exc  out  1  overflow exception flag
- out_epc  out  DATA_W  PC of the trapping instruction; 0 when out_exc=0

## Operation
- Accept when in_valid && in_ready. Output handshake when out_valid && out_ready.
- Storage consists of a main entry, which drives the outputs, and a skid entry.
- On accept, if the main entry is empty or is being drained this cycle, the input loads main. Otherwise it loads skid.
- On drain with skid valid, skid moves to main.
- in_ready = !skid_valid && state==RUN.
- Overflow detection is done in this block and does not use the ALU's overflow port:
  - ADD: ovf = (a[31]==b[31]) && (c[31]!=a[31])
  - SUB: ovf = (a[31]!=b[31]) && (c[31]!=a[31])
  - All other aluc values: ovf = 0
- An entry captured with ovf=1 stores wen=0, exc=1, epc=pc_in. Its result and flags are stored unchanged.
- State machine:
  - RUN → EXC when an ovf entry is accepted.
  - EXC → RUN only on flush.
  - In EXC, in_ready=0. Already-buffered entries, including the trapping one, still drain normally.
- Flush clears main and skid valid bits and sets state to RUN. Flush has priority over a simultaneous accept, so the incoming data is dropped. An output handshake in the same cycle still counts as completed downstream.
- rst: all valids 0, state RUN, all data registers 0.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
- Throughput is 1 entry/cycle while out_ready=1.
- When out_ready falls, one further accept is absorbed by skid, then in_ready drops on the next cycle.
- Outputs hold stable while out_valid && !out_ready.
- Reset values: in_ready=1, out_valid=0, out_c=0, out_zero=0, out_carry=0, out_negative=0, out_rd=0, out_wen=0, out_exc=0, out_epc=0.
- rst asserted mid-transfer discards all entries on the next edge. No output handshake is reported for that cycle.
- in_valid with in_ready=0 is ignored. Upstream must hold its data.

## Configuration
- ALU_OVF_TRAP_EN defined: overflow detection, wen suppression, out_exc/out_epc and the EXC state are all present, as described above.
- ALU_OVF_TRAP_EN undefined:
  - No detection logic and no EXC state; state is permanently RUN.
  - out_exc=0 and out_epc=0 constant.
  - wen_in passes through unchanged.

## Test plan
- Reset, then 3 back-to-back accepts with out_ready=1: c=0x00000005, 0xFFFFFFFF, 0x0 → each appears 1 cycle later with wen preserved; out_zero=1 only on the third.
- ADD a=0x7FFFFFFF, b=0x00000001, c=0x80000000, pc=0x00400010 (macro on) → out_exc=1, out_wen=0, out_epc=0x00400010, in_ready=0 until flush. Flush → in_ready=1 next cycle.
- SUB a=0x80000000, b=0x00000001, c=0x7FFFFFFF → exc=1. ADDU with the same operands as the ADD case → exc=0, wen=1.
- out_ready=0 with in_valid held high → second entry lands in skid, in_ready=0. Release out_ready → entries emerge in order on consecutive cycles, with no loss or duplication.
- flush asserted together with in_valid while skid and main are full → out_valid=0 next cycle and the incoming entry is never seen.
- Macro off, repeat the ADD overflow case → out_exc=0, out_wen=1, in_ready stays 1.
